cipu_stream_buffer: RTL and testbench

- Parametrised successor of the character-stream queue/stack unit; one storage engine serves both modes, selected per session by mode_in.
- Queue mode: filters an incoming character stream and replays accepted characters in arrival order.
- Stack mode: pushes items and pops a requested count at each separator. At end-of-stream it drains the remaining items bottom-to-top.
- Adds a parametrised width/depth/delimiters, input valid/ready, output backpressure, and overflow/underflow flags.

---
 rtl/cipu_stream_pkg.sv | 20 ++
 rtl/cipu_stream_mem.sv | 47 ++++
 rtl/cipu_stream_buffer.sv | 155 +++++++++++++++
 tb/tb_cipu_stream_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cipu_stream_pkg.sv
// cipu_stream_pkg: shared states, output tags and default characters for the stream buffer.
package cipu_stream_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE     = 3'd0;
    localparam state_t LOAD     = 3'd1;
    localparam state_t POP      = 3'd2;
    localparam state_t SEG_DONE = 3'd3;
    localparam state_t END_SEG  = 3'd4;
    localparam state_t DRAIN    = 3'd5;
    localparam state_t ALL_DONE = 3'd6;
    localparam logic [1:0] TAG_QUEUE = 2'd0;
    localparam logic [1:0] TAG_POP   = 2'd1;
    localparam logic [1:0] TAG_DRAIN = 2'd2;
    localparam logic [7:0] DEF_END_CHAR   = 8'h24;
    localparam logic [7:0] DEF_SEP_CHAR   = 8'h3B;
    localparam logic [7:0] DEF_LO_CHAR    = 8'h41;
    localparam logic [7:0] DEF_HI_CHAR    = 8'h5A;
    localparam logic [7:0] DEF_EMPTY_CHAR = 8'h30;
    localparam logic [7:0] FOLD_OFS       = 8'h20;
endpackage

// File: rtl/cipu_stream_mem.sv
// cipu_stream_mem: non-wrapping storage array with head/top pointers, async read by index.
module cipu_stream_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              head_inc,
    input  logic              top_dec,
    input  logic [PTR_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [PTR_W-1:0]  head,
    output logic [PTR_W-1:0]  top,
    output logic              full,
    output logic              empty
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, top_q, top_d;
    logic              wr_ok;
    assign wr_ok = wr_en && !full;
    always_comb begin
        head_d = clr ? '0 : head_q + PTR_W'(head_inc);
        top_d  = clr ? '0 : top_q + PTR_W'(wr_ok) - PTR_W'(top_dec);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            top_q  <= '0;
        end else begin
            head_q <= head_d;
            top_q  <= top_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[top_q[IDX_W-1:0]] <= wr_data;
    end
    assign rd_data = mem_q[rd_idx[IDX_W-1:0]];
    assign head    = head_q;
    assign top     = top_q;
    assign full    = top_q == PTR_W'(DEPTH);
    assign empty   = top_q == head_q;
endmodule

// File: rtl/cipu_stream_buffer.sv
// cipu_stream_buffer: queue/stack character stream unit with registered, backpressured output.
// Optional CIPU_CASE_FOLD_EN: queue mode folds 'a'..'z' to upper case instead of dropping it.
module cipu_stream_buffer
    import cipu_stream_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 16,
    parameter logic [DATA_W-1:0] END_CHAR   = DATA_W'(DEF_END_CHAR),
    parameter logic [DATA_W-1:0] SEP_CHAR   = DATA_W'(DEF_SEP_CHAR),
    parameter logic [DATA_W-1:0] LO_CHAR    = DATA_W'(DEF_LO_CHAR),
    parameter logic [DATA_W-1:0] HI_CHAR    = DATA_W'(DEF_HI_CHAR),
    parameter logic [DATA_W-1:0] EMPTY_CHAR = DATA_W'(DEF_EMPTY_CHAR),
    parameter int                CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_in,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  in_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_tag,
    output logic              done_seg,
    output logic              done_all,
    output logic              overflow,
    output logic              underflow,
    output logic              busy
);
    localparam logic [DATA_W-1:0] FOLD = DATA_W'(FOLD_OFS);
    state_t            state_q, state_d;
    logic              mode_q, mode_d, zflag_q, zflag_d, pend_q, pend_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] out_data_q, out_data_d, st_data, rd_data;
    logic [1:0]        out_tag_q, out_tag_d;
    logic [CNT_W-1:0]  rd_idx, head, top;
    logic              clr, wr_en, full, empty, hs, free, pop_done, drn_done;
    logic              stk_empty, drn_more, in_rng, fold_rng, qual;
    cipu_stream_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(CNT_W)) u_mem (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(st_data),
        .head_inc(drn_done), .top_dec(pop_done), .rd_idx(rd_idx), .rd_data(rd_data),
        .head(head), .top(top), .full(full), .empty(empty)
    );
    // Pointers move only on a completed handshake, so the next item is looked up one slot ahead.
    assign hs        = out_valid_q && out_ready;
    assign free      = !out_valid_q || out_ready;
    assign pop_done  = hs && pend_q && state_q == POP;
    assign drn_done  = hs && pend_q && state_q == DRAIN;
    assign stk_empty = pop_done ? (top - CNT_W'(1) == head) : empty;
    assign drn_more  = drn_done ? (head + CNT_W'(1) != top) : !empty;
    assign rd_idx    = state_q == DRAIN ? head + CNT_W'(drn_done) : top - CNT_W'(pop_done) - CNT_W'(1);
    assign in_rng    = in_data >= LO_CHAR && in_data <= HI_CHAR;
`ifdef CIPU_CASE_FOLD_EN
    assign fold_rng  = !mode_q && in_data >= LO_CHAR + FOLD && in_data <= HI_CHAR + FOLD;
`else
    assign fold_rng  = 1'b0;
`endif
    assign qual      = mode_q || in_rng || fold_rng;
    assign st_data   = fold_rng ? in_data - FOLD : in_data;
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        rem_d       = rem_q;
        zflag_d     = zflag_q;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_valid_d ? out_data_q : EMPTY_CHAR;
        out_tag_d   = out_tag_q;
        clr         = 1'b0;
        wr_en       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                mode_d  = mode_in;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                clr     = 1'b1;
            end
            LOAD: if (in_valid) begin
                if (in_data == END_CHAR) state_d = mode_q ? END_SEG : DRAIN;
                else if (mode_q && in_data == SEP_CHAR) begin
                    rem_d   = in_cnt;
                    zflag_d = in_cnt == '0;
                    state_d = POP;
                end else if (qual) begin
                    ovf_d = ovf_q || full;
                    wr_en = !full;
                end
            end
            POP: if (free) begin
                if (zflag_q || rem_q != '0) begin
                    out_valid_d = 1'b1;
                    out_tag_d   = TAG_POP;
                    pend_d      = !zflag_q && !stk_empty;
                    out_data_d  = pend_d ? rd_data : EMPTY_CHAR;
                    unf_d       = unf_q || (!zflag_q && stk_empty);
                    rem_d       = zflag_q ? rem_q : rem_q - CNT_W'(1);
                    zflag_d     = 1'b0;
                end else state_d = SEG_DONE;
            end
            SEG_DONE: state_d = LOAD;
            END_SEG:  state_d = DRAIN;
            DRAIN: if (free) begin
                if (drn_more) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data;
                    out_tag_d   = mode_q ? TAG_DRAIN : TAG_QUEUE;
                    pend_d      = 1'b1;
                end else state_d = ALL_DONE;
            end
            ALL_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            rem_q       <= '0;
            zflag_q     <= 1'b0;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= EMPTY_CHAR;
            out_tag_q   <= TAG_QUEUE;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rem_q       <= rem_d;
            zflag_q     <= zflag_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end
    assign in_ready  = state_q == LOAD;
    assign busy      = state_q != IDLE;
    assign done_seg  = state_q == SEG_DONE || state_q == END_SEG;
    assign done_all  = state_q == ALL_DONE;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_cipu_stream_buffer.sv
// tb_cipu_stream_buffer: directed stimulus with a scoreboard of expected outputs and done pulses.
module tb_cipu_stream_buffer;
    localparam logic [1:0] K_OUT = 2'd0, K_SEG = 2'd1, K_ALL = 2'd2;
    logic       clk = 0, rst = 1, mode_in = 0, start = 0, in_valid = 0, out_ready = 1;
    logic [7:0] in_data = 0;
    logic [4:0] in_cnt = 0;
    logic       in_ready, out_valid, done_seg, done_all, overflow, underflow, busy;
    logic [7:0] out_data;
    logic [1:0] out_tag;
    logic [11:0] sb[$];
    int n_checks = 0, n_fail = 0;

    cipu_stream_buffer dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_cnt(in_cnt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .done_seg(done_seg),
        .done_all(done_all), .overflow(overflow), .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    function automatic void push(input logic [1:0] k, input logic [7:0] d, input logic [1:0] t);
        sb.push_back({k, d, t});
    endfunction

    function automatic void pop_cmp(input string nm, input logic [11:0] act);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s unexpected event got=%0h exp=none", nm, act);
        end else check(nm, act, sb.pop_front());
    endfunction

    always @(negedge clk) if (!rst) begin
        if (done_seg || done_all) check("no_overlap", out_valid, 0);
        if (out_valid && out_ready) pop_cmp("out", {K_OUT, out_data, out_tag});
        if (done_seg) pop_cmp("done_seg", {K_SEG, 8'h00, 2'b00});
        if (done_all) pop_cmp("done_all", {K_ALL, 8'h00, 2'b00});
    end

    task automatic begin_session(input logic m);
        for (int i = 0; i < 300 && busy; i++) begin @(posedge clk); #1; end
        mode_in = m;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input logic [7:0] ch, input logic [4:0] cnt);
        bit got = 0;
        in_data = ch;
        in_cnt = cnt;
        in_valid = 1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout got=in_ready_low exp=handshake");
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 0);
    endtask

    task automatic wait_sb(input string nm);
        for (int i = 0; i < 400 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        check(nm, sb.size(), 0);
    endtask

    initial begin
        start = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        start = 0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h30);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_flags", {done_seg, done_all, overflow, underflow}, 0);
        @(posedge clk); #1;

        // queue replay with filter
        begin_session(0);
        push(K_OUT, "A", 0);
`ifdef CIPU_CASE_FOLD_EN
        push(K_OUT, "B", 0);
`endif
        push(K_OUT, "C", 0); push(K_OUT, "D", 0); push(K_ALL, 0, 0);
        send_str("Ab1CD");
        send("$", 0);
        check("q_lat_idle", out_valid, 0);
        @(posedge clk); #1;
        check("q_first", {out_valid, out_data}, {1'b1, 8'h41});
        @(posedge clk); #1;
        check("q_second_valid", out_valid, 1);
        @(posedge clk); #1;
        check("q_third_valid", out_valid, 1);
        wait_sb("q_done");
        check("q_overflow", overflow, 0);

        // stack pop then drain
        begin_session(1);
        send_str("XYZ");
        push(K_OUT, "Z", 1); push(K_OUT, "Y", 1); push(K_SEG, 0, 0);
        send(";", 2);
        push(K_SEG, 0, 0); push(K_OUT, "X", 2); push(K_ALL, 0, 0);
        send("$", 0);
        wait_sb("s_done");

        // stack zero count and underflow
        begin_session(1);
        send("Q", 0);
        push(K_OUT, "0", 1); push(K_SEG, 0, 0);
        send(";", 0);
        wait_sb("z_seg");
        check("z_no_underflow", underflow, 0);
        push(K_OUT, "Q", 1); push(K_OUT, "0", 1); push(K_OUT, "0", 1); push(K_SEG, 0, 0);
        send(";", 3);
        wait_sb("u_seg");
        check("u_underflow", underflow, 1);
        push(K_SEG, 0, 0); push(K_ALL, 0, 0);
        send("$", 0);
        wait_sb("u_done");

        // backpressure holds 'B'
        begin_session(0);
        push(K_OUT, "A", 0); push(K_OUT, "B", 0); push(K_OUT, "C", 0); push(K_ALL, 0, 0);
        send_str("ABC$");
        for (int i = 0; i < 20 && !(out_valid && out_data == "B"); i++) begin @(posedge clk); #1; end
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {out_valid, out_data, out_tag}, {1'b1, 8'h42, 2'd0});
        end
        out_ready = 1;
        wait_sb("bp_done");

        // overflow on the 17th letter
        begin_session(0);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) push(K_OUT, 8'h41 + 8'(i), 0);
            send(8'h41 + 8'(i), 0);
        end
        push(K_ALL, 0, 0);
        send("$", 0);
        wait_sb("ov_done");
        check("ov_overflow", overflow, 1);

        // reset while draining aborts without done_all
        begin_session(0);
        out_ready = 0;
        send_str("ABCD$");
        repeat (3) @(posedge clk);
        #1;
        check("rd_stuck_busy", busy, 1);
        rst = 1;
        @(negedge clk);
        check("rd_out_valid", out_valid, 0);
        check("rd_busy", busy, 0);
        @(posedge clk); #1;
        rst = 0;
        out_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        check("rd_idle", busy, 0);

        // new session after abort: lower-case handling
        begin_session(0);
        check("cf_ovf_cleared", overflow, 0);
`ifdef CIPU_CASE_FOLD_EN
        push(K_OUT, "A", 0); push(K_OUT, "B", 0);
`endif
        push(K_ALL, 0, 0);
        send_str("ab$");
        wait_sb("cf_done");

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
